// File: rtl/fast_control_rx.sv
// fast_control_rx
//
// Receive-side decoder for the fast-control stream. Each clk_bx the 16-bit
// encoded word is registered (S1), both Hamming(8,4) bytes are decoded and
// corrected, and all outputs are registered (S2). The outputs are command
// strobes, a recovered bunch-crossing number with a BCR lock state machine,
// and saturating error/trigger counters.
//
// Byte code (hamming84_enc), bit index = Hamming position:
//   [0] overall parity of bits 7:1 (even)
//   [1] p1 = d0^d1^d3   [2] p2 = d0^d2^d3   [4] p4 = d1^d2^d3
//   [3] d0  [5] d1  [6] d2  [7] d3
//
// Ports:
//   clk_bx         bunch-crossing clock
//   reset          asynchronous active-high reset
//   fc_stream_enc  encoded word, [7:0] low nibble, [15:8] high nibble
//   orb_length     orbit length in bx (>= 2)
//   err_clear      synchronous clear of all counters
//   bcr, l1a, link_reset, buffer_clear   strobes, decoded bits 0..3
//   calib_pulse    decoded bit 5
//   aux            decoded bits {7,6,4}
//   bx_id          recovered bunch-crossing number
//   locked         lock FSM is in LOCKED
//   sec_count, ded_count, l1a_count, unlock_count   saturating counters
//
// Lock FSM states:
//   state       | meaning
//   UNLOCKED    | waiting for any BCR, bx_id held at 0
//   CHECK       | counting BCRs that land in the expected slot
//   LOCKED      | aligned; counting misplaced/missing BCRs
module fast_control_rx #(
    parameter int ORB_LEN_W = 12,
    parameter int LOCK_GOOD = 3,
    parameter int LOCK_MISS = 2
) (
    input  logic                 clk_bx,
    input  logic                 reset,
    input  logic [15:0]          fc_stream_enc,
    input  logic [ORB_LEN_W-1:0] orb_length,
    input  logic                 err_clear,
    output logic                 bcr,
    output logic                 l1a,
    output logic                 link_reset,
    output logic                 buffer_clear,
    output logic                 calib_pulse,
    output logic [2:0]           aux,
    output logic [ORB_LEN_W-1:0] bx_id,
    output logic                 locked,
    output logic [15:0]          sec_count,
    output logic [15:0]          ded_count,
    output logic [31:0]          l1a_count,
    output logic [7:0]           unlock_count
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_CHECK    = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam logic [7:0]         GOOD_TGT = 8'(LOCK_GOOD);
    localparam logic [7:0]         MISS_TGT = 8'(LOCK_MISS);
    localparam logic [ORB_LEN_W:0] ONE_EXT  = 1;

    // Returns {single_err, double_err, data[3:0]}.
    function automatic logic [5:0] dec84(input logic [7:0] b);
        logic [2:0] syn;
        logic       par_err;
        logic       dbl;
        logic [7:0] c;
        logic [3:0] d;
        syn     = {b[4] ^ b[5] ^ b[6] ^ b[7],
                   b[2] ^ b[3] ^ b[6] ^ b[7],
                   b[1] ^ b[3] ^ b[5] ^ b[7]};
        par_err = ^b;
        c       = b;
        if (par_err && (syn != 3'd0)) begin
            c[syn] = ~c[syn];
        end
        dbl = !par_err && (syn != 3'd0);
        // Uncorrectable nibble is zeroed so it can never fire a command.
        d   = dbl ? 4'd0 : {c[7], c[6], c[5], c[3]};
        return {par_err, dbl, d};
    endfunction

    logic [15:0] enc_q;
    logic [5:0]  dec_lo;
    logic [5:0]  dec_hi;
    logic [7:0]  dec_data;
    logic [1:0]  sec_inc;
    logic [1:0]  ded_inc;

    assign dec_lo   = dec84(enc_q[7:0]);
    assign dec_hi   = dec84(enc_q[15:8]);
    assign dec_data = {dec_hi[3:0], dec_lo[3:0]};
    assign sec_inc  = {1'b0, dec_lo[5]} + {1'b0, dec_hi[5]};
    assign ded_inc  = {1'b0, dec_lo[4]} + {1'b0, dec_hi[4]};

    // Lock FSM
    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [7:0]           good_q;
    logic [7:0]           good_d;
    logic [7:0]           miss_q;
    logic [7:0]           miss_d;
    logic [ORB_LEN_W-1:0] bx_d;
    logic [ORB_LEN_W:0]   bx_inc;
    logic                 wrap;
    logic                 unlock_ev;
    logic                 dec_bcr;

    assign dec_bcr = dec_data[0];
    assign bx_inc  = {1'b0, bx_id} + ONE_EXT;
    // ">=" rather than "==" so a shrinking orb_length still wraps.
    assign wrap    = (bx_inc >= {1'b0, orb_length});

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        miss_d    = miss_q;
        unlock_ev = 1'b0;
        bx_d      = wrap ? '0 : bx_inc[ORB_LEN_W-1:0];
        case (state_q)
            ST_UNLOCKED: begin
                bx_d = '0;
                if (dec_bcr) begin
                    good_d  = 8'd1;
                    miss_d  = 8'd0;
                    state_d = (GOOD_TGT <= 8'd1) ? ST_LOCKED : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (wrap) begin
                    if (dec_bcr) begin
                        good_d = good_q + 8'd1;
                        if (good_d >= GOOD_TGT) begin
                            state_d = ST_LOCKED;
                            miss_d  = 8'd0;
                        end
                    end else begin
                        state_d = ST_UNLOCKED;
                        bx_d    = '0;
                    end
                end else if (dec_bcr) begin
                    state_d = ST_UNLOCKED;
                    bx_d    = '0;
                end
            end
            ST_LOCKED: begin
                if (wrap && dec_bcr) begin
                    miss_d = 8'd0;
                end else if (wrap || dec_bcr) begin
                    // Missing slot BCR or misplaced BCR; bx_id keeps counting.
                    miss_d = miss_q + 8'd1;
                    if (miss_d >= MISS_TGT) begin
                        state_d   = ST_UNLOCKED;
                        bx_d      = '0;
                        unlock_ev = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                bx_d    = '0;
            end
        endcase
    end

    // Saturating counter next values
    logic [16:0] sec_sum;
    logic [16:0] ded_sum;
    logic [32:0] l1a_sum;
    logic [8:0]  unlock_sum;
    logic [15:0] sec_next;
    logic [15:0] ded_next;
    logic [31:0] l1a_next;
    logic [7:0]  unlock_next;

    assign sec_sum     = {1'b0, sec_count} + {15'd0, sec_inc};
    assign ded_sum     = {1'b0, ded_count} + {15'd0, ded_inc};
    assign l1a_sum     = {1'b0, l1a_count} + {32'd0, dec_data[1]};
    assign unlock_sum  = {1'b0, unlock_count} + {8'd0, unlock_ev};
    assign sec_next    = sec_sum[16]    ? '1 : sec_sum[15:0];
    assign ded_next    = ded_sum[16]    ? '1 : ded_sum[15:0];
    assign l1a_next    = l1a_sum[32]    ? '1 : l1a_sum[31:0];
    assign unlock_next = unlock_sum[8]  ? '1 : unlock_sum[7:0];

    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            enc_q        <= '0;
            bcr          <= 1'b0;
            l1a          <= 1'b0;
            link_reset   <= 1'b0;
            buffer_clear <= 1'b0;
            calib_pulse  <= 1'b0;
            aux          <= '0;
            state_q      <= ST_UNLOCKED;
            good_q       <= '0;
            miss_q       <= '0;
            bx_id        <= '0;
            locked       <= 1'b0;
            sec_count    <= '0;
            ded_count    <= '0;
            l1a_count    <= '0;
            unlock_count <= '0;
        end else begin
            enc_q        <= fc_stream_enc;
            bcr          <= dec_data[0];
            l1a          <= dec_data[1];
            link_reset   <= dec_data[2];
            buffer_clear <= dec_data[3];
            calib_pulse  <= dec_data[5];
            aux          <= {dec_data[7], dec_data[6], dec_data[4]};
            state_q      <= state_d;
            good_q       <= good_d;
            miss_q       <= miss_d;
            bx_id        <= bx_d;
            locked       <= (state_d == ST_LOCKED);
            if (err_clear) begin
                sec_count    <= '0;
                ded_count    <= '0;
                l1a_count    <= '0;
                unlock_count <= '0;
            end else begin
                sec_count    <= sec_next;
                ded_count    <= ded_next;
                l1a_count    <= l1a_next;
                unlock_count <= unlock_next;
            end
        end
    end

endmodule

// File: doc/fast_control_rx.md
# fast_control_rx

Receive-side decoder for the fast-control stream, run on each front-end link endpoint. Accepts the 16-bit Hamming(8,4)-encoded word produced once per `clk_bx` by the fast-control encoder and corrects single-bit errors per nibble. Turns the decoded bits into single-cycle command strobes, recovers bunch-crossing alignment from BCR with a lock state machine, and keeps saturating error and trigger counters for slow-control readout.

## Interface
- `ORB_LEN_W`, 12: width of bx counter and `orb_length`.
- `LOCK_GOOD`, 3: consecutive correctly placed BCRs needed to declare lock.
- `LOCK_MISS`, 2: consecutive misplaced or missing BCRs that drop lock.

Ports:
- `clk_bx`  in  1  bunch-crossing clock; sole clock of the block.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `fc_stream_enc`  in  16  encoded word.
  - [7:0] is the low nibble (bits 3:0).
  - [15:8] is the high nibble (bits 7:4).
  - Both bytes use the code of `hamming84_enc`.
- `orb_length`  in  ORB_LEN_W  orbit length in bx; quasi-static; valid range ≥2.
- `err_clear`  in  1  synchronous clear of all counters.
- `bcr`, `l1a`, `link_reset`, `buffer_clear`  out  1 each  strobes from decoded bits 0, 1, 2, 3.
- `calib_pulse`  out  1  decoded bit 5; level, passed through as-is.
- `aux`  out  3  decoded bits {7,6,4}; quasi-static debug bits.
- `bx_id`  out  ORB_LEN_W  recovered bunch-crossing number.
- `locked`  out  1  high in LOCKED state.
- `sec_count`  out  16  corrected single-error nibbles.
- `ded_count`  out  16  uncorrectable double-error nibbles.
- `l1a_count`  out  32  accepted L1As.
- `unlock_count`  out  8  LOCKED→UNLOCKED transitions.

## Operation
**Pipeline**
- S1 registers `fc_stream_enc`.
- S2 decodes both bytes independently and registers all outputs.

**Per-byte decode (exact inverse of `hamming84_enc`)**
- Syndrome 0, overall parity OK: data used as-is.
- Syndrome ≠0, overall parity fails: single error. Flip the indicated bit, use the corrected data, increment `sec_count`.
- Syndrome 0, overall parity fails: parity-bit error. Data used as-is, increment `sec_count`.
- Syndrome ≠0, overall parity OK: double error. Force that nibble's 4 data bits to 0 (no spurious commands), increment `ded_count`.
- Both bytes erroneous in one cycle: each counter adds the number of affected bytes (+2 possible).

**Strobe outputs**
- `bcr`, `l1a`, `link_reset`, `buffer_clear` equal the decoded bit for that cycle.
- The encoder already sends one-cycle pulses; no edge detection is added.
- `l1a_count` increments on every cycle with `l1a`=1.

**Lock FSM: states UNLOCKED, CHECK, LOCKED**
- The expected BCR slot is a cycle where the free-running `bx_id` wraps, i.e. the next value is 0.
- `bx_id` counts 0..`orb_length`−1 and then wraps.
- UNLOCKED:
  - `bx_id` holds 0.
  - Decoded BCR → CHECK, `bx_id`=0 on that same output cycle, good=1.
- CHECK:
  - BCR in the expected slot: good+1; good reaching `LOCK_GOOD` → LOCKED.
  - BCR at any other `bx_id`, or no BCR in the expected slot: → UNLOCKED.
- LOCKED:
  - BCR in slot clears the miss counter.
  - A misplaced BCR or a missing expected BCR each add miss+1 (once per orbit).
  - Reaching `LOCK_MISS` → UNLOCKED, `unlock_count`+1.
  - A misplaced BCR does not realign `bx_id`.
- `orb_length` change mid-operation: no special handling; a misplaced BCR naturally drops lock.

**Counters**
- All counters saturate at all-ones.
- `err_clear` zeroes all counters. If it coincides with an increment, the clear wins and the result is 0.
- `err_clear` does not affect the FSM.

## Timing
- Latency: encoded word at `fc_stream_enc` in cycle N → decoded outputs registered and visible in cycle N+2.
- Counter updates occur in the same cycle as the corresponding output.
- Reset values: all outputs 0, FSM UNLOCKED, `bx_id`=0, all counters 0.
- Reset asserted mid-operation clears state immediately (asynchronously).
- Outputs after reset:
  - The first decoded word appears 2 cycles after reset deassertion.
  - Pipeline registers reset to 0, which decodes as an all-zero word; no command is emitted.
- LOCKED takes effect (`locked`=1) in the same cycle as the `LOCK_GOOD`-th correctly placed BCR.
- Unlock: `locked` falls in the cycle of the `LOCK_MISS`-th miss.

## Test plan
- **Clean stream:** `orb_length`=45, encoded BCR every 45 cycles, L1A word at bx 10.
  - `l1a` pulses at `bx_id`=10.
  - `locked` rises at the 3rd BCR.
  - `sec_count`=`ded_count`=0.
- **Single-bit errors:** flip each of the 8 bits of byte 0 in turn on an L1A word.
  - Every `l1a` still seen.
  - `sec_count`=8, `l1a_count`=8.
- **Double errors:** flip 2 bits in both bytes of a word carrying L1A plus calib (0x22).
  - No `l1a`, no `calib_pulse`.
  - `ded_count`=2.
- **Lock loss:** after lock, omit 2 consecutive BCRs.
  - `locked` falls at the second expected slot.
  - `unlock_count`=1.
  - The next BCR restarts CHECK.
- **Early BCR in CHECK:** BCR at bx 20 after the initial BCR → FSM returns to UNLOCKED, `locked` stays 0.
- **Counter saturation and clear:**
  - Force 70000 single errors → `sec_count`=0xFFFF.
  - Pulse `err_clear` together with an error → counter=0.
  - Assert `reset` mid-orbit → all outputs 0 immediately.
